// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
//
// Credit-accumulation and vend controller for the vending machine. Consumes
// single-cycle pulses from the button debouncers (coins, item select, cancel),
// tracks credit in cents, dispenses an item when the credit covers its price,
// rejects over-limit or simultaneous coins, and pays change out one coin at a
// time with a fixed idle gap between coin-return pulses.
//
// Parameters:
//   PRICE_0..PRICE_3  item prices in cents (multiples of 5)
//   MAX_CREDIT        credit ceiling in cents (multiple of 5, <= 255)
//   GAP_CYCLES        idle cycles after each change pulse (>= 1)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   coin_n/coin_d/coin_q       nickel/dime/quarter insert pulses
//   sel_valid, sel[1:0]        item-select pulse and item index
//   cancel                     cancel/refund pulse
//   credit[7:0]                current credit in cents
//   busy                       high while vending or paying change
//   dispense, item[1:0]        1-cycle vend strobe and the vended item
//   insufficient               1-cycle pulse: select with too little credit
//   coin_reject                1-cycle pulse: at least one coin was rejected
//   change_n/change_d/change_q 1-cycle coin-return pulses
//
// All outputs are registered: an input sampled at edge t shows its effect in
// the cycle following that edge.
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
    parameter int PRICE_0    = 50,
    parameter int PRICE_1    = 75,
    parameter int PRICE_2    = 100,
    parameter int PRICE_3    = 125,
    parameter int MAX_CREDIT = 200,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_n,
    input  logic       coin_d,
    input  logic       coin_q,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       busy,
    output logic       dispense,
    output logic [1:0] item,
    output logic       insufficient,
    output logic       coin_reject,
    output logic       change_n,
    output logic       change_d,
    output logic       change_q
);

    // Gap counter must hold GAP_CYCLES itself.
    localparam int             GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [8:0]     MAX9     = 9'(MAX_CREDIT);
    localparam logic [7:0]     P0       = 8'(PRICE_0);
    localparam logic [7:0]     P1       = 8'(PRICE_1);
    localparam logic [7:0]     P2       = 8'(PRICE_2);
    localparam logic [7:0]     P3       = 8'(PRICE_3);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t          state_q;
    logic [7:0]      credit_q;
    logic [1:0]      item_q;
    logic            busy_q;
    logic            dispense_q;
    logic            ins_q;
    logic            rej_q;
    logic            chg_n_q;
    logic            chg_d_q;
    logic            chg_q_q;
    logic [GW-1:0]   gap_q;

    // Combinational helpers for the COLLECT decision and change selection.
    logic [7:0]      coin_val;
    logic            coin_any;
    logic            coin_multi;
    logic [7:0]      price;
    logic            sel_take;
    logic [7:0]      base;
    logic [8:0]      sum;
    logic            coin_ok;
    logic            reject;
    logic [7:0]      credit_d;
    logic [7:0]      pay_src;
    logic [7:0]      pay_val;

    always_comb begin
        coin_any   = coin_n | coin_d | coin_q;
        coin_multi = (coin_n & coin_d) | (coin_n & coin_q) | (coin_d & coin_q);

        // Only the highest-value asserted coin is considered for acceptance.
        if (coin_q)      coin_val = 8'd25;
        else if (coin_d) coin_val = 8'd10;
        else if (coin_n) coin_val = 8'd5;
        else             coin_val = 8'd0;

        case (sel)
            2'd0:    price = P0;
            2'd1:    price = P1;
            2'd2:    price = P2;
            default: price = P3;
        endcase

        // Price is checked against the credit held before this cycle's coin;
        // cancel wins over select.
        sel_take = sel_valid && !cancel && (credit_q >= price);
        base     = sel_take ? (credit_q - price) : credit_q;

        // Coin ceiling is checked against the post-purchase credit.
        sum      = {1'b0, base} + {1'b0, coin_val};
        coin_ok  = coin_any && (sum <= MAX9);
        credit_d = coin_ok ? sum[7:0] : base;

        // Any asserted coin that is not the single accepted one is rejected.
        reject   = coin_any && (!coin_ok || coin_multi);

        // On cancel the first payout happens straight away, including any
        // coin accepted in the same cycle.
        pay_src  = (state_q == S_COLLECT) ? credit_d : credit_q;
        if (pay_src >= 8'd25)      pay_val = 8'd25;
        else if (pay_src >= 8'd10) pay_val = 8'd10;
        else                       pay_val = 8'd5;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_COLLECT;
            credit_q   <= 8'd0;
            item_q     <= 2'd0;
            busy_q     <= 1'b0;
            dispense_q <= 1'b0;
            ins_q      <= 1'b0;
            rej_q      <= 1'b0;
            chg_n_q    <= 1'b0;
            chg_d_q    <= 1'b0;
            chg_q_q    <= 1'b0;
            gap_q      <= '0;
        end else begin
            // Strobes default low; each is asserted for one cycle only.
            dispense_q <= 1'b0;
            ins_q      <= 1'b0;
            chg_n_q    <= 1'b0;
            chg_d_q    <= 1'b0;
            chg_q_q    <= 1'b0;

            case (state_q)
                S_COLLECT: begin
                    rej_q    <= reject;
                    credit_q <= credit_d;
                    if (cancel && (credit_q != 8'd0)) begin
                        state_q  <= S_CHANGE;
                        busy_q   <= 1'b1;
                        credit_q <= pay_src - pay_val;
                        chg_q_q  <= (pay_val == 8'd25);
                        chg_d_q  <= (pay_val == 8'd10);
                        chg_n_q  <= (pay_val == 8'd5);
                        gap_q    <= GAP_LOAD;
                    end else if (sel_take) begin
                        state_q    <= S_VEND;
                        busy_q     <= 1'b1;
                        dispense_q <= 1'b1;
                        item_q     <= sel;
                    end else if (sel_valid && !cancel) begin
                        ins_q <= 1'b1;
                    end
                end

                S_VEND: begin
                    rej_q <= coin_any;
                    if (credit_q != 8'd0) begin
                        state_q  <= S_CHANGE;
                        credit_q <= pay_src - pay_val;
                        chg_q_q  <= (pay_val == 8'd25);
                        chg_d_q  <= (pay_val == 8'd10);
                        chg_n_q  <= (pay_val == 8'd5);
                        gap_q    <= GAP_LOAD;
                    end else begin
                        state_q <= S_COLLECT;
                        busy_q  <= 1'b0;
                    end
                end

                S_CHANGE: begin
                    rej_q <= coin_any;
                    // gap_q counts down the idle cycles after each pulse; the
                    // decision for the next pulse is made when it reaches zero.
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (credit_q == 8'd0) begin
                        state_q <= S_COLLECT;
                        busy_q  <= 1'b0;
                    end else begin
                        credit_q <= pay_src - pay_val;
                        chg_q_q  <= (pay_val == 8'd25);
                        chg_d_q  <= (pay_val == 8'd10);
                        chg_n_q  <= (pay_val == 8'd5);
                        gap_q    <= GAP_LOAD;
                    end
                end

                default: begin
                    state_q <= S_COLLECT;
                    busy_q  <= 1'b0;
                    rej_q   <= 1'b0;
                end
            endcase
        end
    end

    assign credit       = credit_q;
    assign busy         = busy_q;
    assign dispense     = dispense_q;
    assign item         = item_q;
    assign insufficient = ins_q;
    assign coin_reject  = rej_q;
    assign change_n     = chg_n_q;
    assign change_d     = chg_d_q;
    assign change_q     = chg_q_q;

endmodule
